// File: rtl/mac_tx_sched_pkg.sv
// Shared types and constants for the MAC transmit scheduler.
package mac_tx_sched_pkg;

  localparam int IFG_CYCLES      = 48;    // 96 bit times at 2 bits per clk
  localparam int START_TIMEOUT   = 16;    // doorbell-to-busy limit before abort
  localparam int ADDR_W          = 11;    // packet-buffer max address width
  localparam int MAX_FRAME_BYTES = 1518;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RING,
    ST_WAIT_START,
    ST_WAIT_END,
    ST_GAP
  } state_e;

  // One-hot grant/done vector for a requester index.
  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mac_tx_sched_if.sv
// Handshake between the scheduler and the RMII MAC transmitter.
interface mac_tx_sched_if
  import mac_tx_sched_pkg::*;
#(
  parameter int ADDR_W = mac_tx_sched_pkg::ADDR_W
);

  logic              tx_doorbell;   // one-cycle start request
  logic [ADDR_W-1:0] tx_maxaddr;    // last byte index of the frame to send
  logic              tx_available;  // transmitter idle and ready

  // Scheduler side.
  modport master (
    output tx_doorbell,
    output tx_maxaddr,
    input  tx_available
  );

  // Transmitter side.
  modport slave (
    input  tx_doorbell,
    input  tx_maxaddr,
    output tx_available
  );

endinterface

// File: rtl/mac_tx_sched_rr_arb2.sv
// Two-way round-robin pick; purely combinational, the caller keeps rr_last.
module mac_tx_sched_rr_arb2 (
  input  logic [1:0] req,
  input  logic       rr_last,
  output logic       valid,
  output logic       winner
);

  // Single requester wins outright; a tie goes to whoever was not served last.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    valid  = |req;
    winner = 1'b0;
    unique case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~rr_last;
      default: winner = 1'b0;
    endcase
  end

endmodule

// File: rtl/mac_tx_sched.sv
// Shares the RMII MAC transmitter between two frame requesters: round-robin
// arbitration, doorbell, start timeout, end-of-frame detection and the
// inter-frame gap. sel steers the packet-buffer mux in the wrapper.
module mac_tx_sched
  import mac_tx_sched_pkg::*;
#(
  parameter int IFG_CYCLES    = mac_tx_sched_pkg::IFG_CYCLES,
  parameter int START_TIMEOUT = mac_tx_sched_pkg::START_TIMEOUT,
  parameter int ADDR_W        = mac_tx_sched_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  input  logic [ADDR_W-1:0] maxaddr0,
  input  logic [ADDR_W-1:0] maxaddr1,
  output logic [1:0]        grant,
  output logic [1:0]        done,
  output logic              abort,
  output logic              sel,
  output logic              busy,
  mac_tx_sched_if.master    tx
);

  // One counter serves both the start timeout and the gap; size it for the larger.
  localparam int CNT_MAX = (IFG_CYCLES > START_TIMEOUT) ? IFG_CYCLES : START_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(START_TIMEOUT);
  localparam logic [CNT_W-1:0] GAP_LOAD     = CNT_W'(IFG_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO     = '0;

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic             rr_last;
  logic             arb_valid;
  logic             arb_winner;

  mac_tx_sched_rr_arb2 u_arb (
    .req     (req),
    .rr_last (rr_last),
    .valid   (arb_valid),
    .winner  (arb_winner)
  );

  // Scheduler FSM; every output is registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: state and outputs use non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      state          <= ST_IDLE;
      cnt            <= CNT_ZERO;
      rr_last        <= 1'b1;       // requester 0 wins the first tie
      grant          <= 2'b00;
      done           <= 2'b00;
      abort          <= 1'b0;
      sel            <= 1'b0;
      busy           <= 1'b0;
      tx.tx_doorbell <= 1'b0;
      tx.tx_maxaddr  <= '0;
    end else begin
      // Pulses default low and are raised for a single cycle below.
      done           <= 2'b00;
      abort          <= 1'b0;
      tx.tx_doorbell <= 1'b0;

      unique case (state)
        ST_IDLE: begin
          // maxaddr is sampled only here; sel/tx_maxaddr then hold until the
          // next decision, so they never move while the transmitter is busy.
          if (arb_valid) begin
            sel           <= arb_winner;
            tx.tx_maxaddr <= arb_winner ? maxaddr1 : maxaddr0;
            grant         <= onehot2(arb_winner);
            rr_last       <= arb_winner;
            busy          <= 1'b1;
            state         <= ST_RING;
          end
        end

        ST_RING: begin
          tx.tx_doorbell <= 1'b1;
          cnt            <= TIMEOUT_LOAD;
          state          <= ST_WAIT_START;
        end

        ST_WAIT_START: begin
          // Transmitter going busy marks start of frame. If it is already low
          // (not yet idle after reset) we fall through and close on its rise.
          if (!tx.tx_available) begin
            state <= ST_WAIT_END;
          end else if (cnt == CNT_ONE) begin
            abort <= 1'b1;
            grant <= 2'b00;
            cnt   <= GAP_LOAD;
            state <= ST_GAP;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end

        ST_WAIT_END: begin
          if (tx.tx_available) begin
            done  <= onehot2(sel);
            grant <= 2'b00;
            cnt   <= GAP_LOAD;
            state <= ST_GAP;
          end
        end

        ST_GAP: begin
          // GAP_LOAD plus the terminal zero cycle gives exactly IFG_CYCLES.
          if (cnt == CNT_ZERO) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end

        default: begin
          busy  <= 1'b0;
          grant <= 2'b00;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_tx_sched.sv
// Self-checking bench for mac_tx_sched with a small behavioural transmitter.
module tb_mac_tx_sched;
  import mac_tx_sched_pkg::*;

  logic              clk;
  logic              rst;
  logic [1:0]        req;
  logic [ADDR_W-1:0] maxaddr0;
  logic [ADDR_W-1:0] maxaddr1;
  logic [1:0]        grant;
  logic [1:0]        done;
  logic              abort;
  logic              sel;
  logic              busy;

  mac_tx_sched_if #(.ADDR_W(ADDR_W)) txif ();

  mac_tx_sched dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .maxaddr0 (maxaddr0),
    .maxaddr1 (maxaddr1),
    .grant    (grant),
    .done     (done),
    .abort    (abort),
    .sel      (sel),
    .busy     (busy),
    .tx       (txif)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Edge counter used to measure distances between events.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter model: sees the doorbell, drops available two cycles after
  // it, stays busy tx_busy_len cycles, then raises available. tx_stuck keeps
  // it available forever to provoke the start timeout.
  logic tx_stuck;
  int   tx_busy_len;
  int   tx_cnt;
  int   tx_phase;

  always @(posedge clk) begin
    if (rst) begin
      txif.tx_available <= 1'b1;
      tx_phase          <= 0;
      tx_cnt            <= 0;
    end else begin
      case (tx_phase)
        0: if (txif.tx_doorbell && !tx_stuck) tx_phase <= 1;
        1: begin
          txif.tx_available <= 1'b0;
          tx_cnt            <= tx_busy_len - 1;
          tx_phase          <= 2;
        end
        default: begin
          if (tx_cnt == 0) begin
            txif.tx_available <= 1'b1;
            tx_phase          <= 0;
          end else begin
            tx_cnt <= tx_cnt - 1;
          end
        end
      endcase
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam int W_DOORBELL = 0;
  localparam int W_DONE     = 1;
  localparam int W_ABORT    = 2;
  localparam int W_TX_LOW   = 3;
  localparam int W_IDLE     = 4;
  localparam int W_GRANT    = 5;

  function automatic bit cond(input int kind);
    case (kind)
      W_DOORBELL: return txif.tx_doorbell == 1'b1;
      W_DONE:     return done != 2'b00;
      W_ABORT:    return abort == 1'b1;
      W_TX_LOW:   return txif.tx_available == 1'b0;
      W_IDLE:     return busy == 1'b0;
      default:    return grant != 2'b00;
    endcase
  endfunction

  // Bounded wait; an expired bound counts as a failed comparison.
  task automatic wait_until(input int kind, input int limit, input string name, output int waited);
    waited = 0;
    while (!cond(kind) && waited < limit) begin
      tick();
      waited++;
    end
    if (!cond(kind)) begin
      tests++;
      fails++;
      $display("FAIL %s: timed out after %0d cycles", name, waited);
    end
  endtask

  typedef struct {
    logic [1:0]        req;
    logic [ADDR_W-1:0] m0;
    logic [ADDR_W-1:0] m1;
    logic [1:0]        exp_grant;
    logic              exp_sel;
    logic [ADDR_W-1:0] exp_maxaddr;
    logic [1:0]        exp_done;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int w;
    int t_done;
    int t_db;
    int t_abort;
    bit done_seen;
    logic [1:0] exp_g;

    // Each row starts from IDLE; rr_last carries across rows (starts at 1).
    vecs[0] = '{req: 2'b01, m0: 11'd63,   m1: 11'd5,   exp_grant: 2'b01, exp_sel: 1'b0, exp_maxaddr: 11'd63,   exp_done: 2'b01};
    vecs[1] = '{req: 2'b11, m0: 11'd10,   m1: 11'd20,  exp_grant: 2'b10, exp_sel: 1'b1, exp_maxaddr: 11'd20,   exp_done: 2'b10};
    vecs[2] = '{req: 2'b11, m0: 11'd2047, m1: 11'd0,   exp_grant: 2'b01, exp_sel: 1'b0, exp_maxaddr: 11'd2047, exp_done: 2'b01};
    vecs[3] = '{req: 2'b01, m0: 11'd7,    m1: 11'd9,   exp_grant: 2'b01, exp_sel: 1'b0, exp_maxaddr: 11'd7,    exp_done: 2'b01};
    vecs[4] = '{req: 2'b10, m0: 11'd3,    m1: 11'd1,   exp_grant: 2'b10, exp_sel: 1'b1, exp_maxaddr: 11'd1,    exp_done: 2'b10};
    vecs[5] = '{req: 2'b10, m0: 11'd4,    m1: 11'd2046, exp_grant: 2'b10, exp_sel: 1'b1, exp_maxaddr: 11'd2046, exp_done: 2'b10};

    rst         = 1'b1;
    req         = 2'b00;
    maxaddr0    = '0;
    maxaddr1    = '0;
    tx_stuck    = 1'b0;
    tx_busy_len = 256;
    repeat (3) tick();

    // Reset state.
    check("rst_grant",    32'(grant), 0);
    check("rst_done",     32'(done), 0);
    check("rst_abort",    32'(abort), 0);
    check("rst_sel",      32'(sel), 0);
    check("rst_doorbell", 32'(txif.tx_doorbell), 0);
    check("rst_maxaddr",  32'(txif.tx_maxaddr), 0);
    check("rst_busy",     32'(busy), 0);

    rst = 1'b0;
    repeat (4) tick();
    check("idle_no_req_busy", 32'(busy), 0);

    // Table-driven single-frame vectors.
    for (int i = 0; i < 6; i++) begin
      req      = vecs[i].req;
      maxaddr0 = vecs[i].m0;
      maxaddr1 = vecs[i].m1;
      tick();                                   // IDLE decision edge
      check($sformatf("v%0d_grant", i),   32'(grant), 32'(vecs[i].exp_grant));
      check($sformatf("v%0d_sel", i),     32'(sel), 32'(vecs[i].exp_sel));
      check($sformatf("v%0d_maxaddr", i), 32'(txif.tx_maxaddr), 32'(vecs[i].exp_maxaddr));
      check($sformatf("v%0d_busy", i),    32'(busy), 1);
      check($sformatf("v%0d_db_early", i), 32'(txif.tx_doorbell), 0);
      tick();                                   // RING edge
      check($sformatf("v%0d_db", i), 32'(txif.tx_doorbell), 1);
      req = 2'b00;                              // dropping req while granted is ignored
      tick();
      check($sformatf("v%0d_db_single", i), 32'(txif.tx_doorbell), 0);
      check($sformatf("v%0d_grant_held", i), 32'(grant), 32'(vecs[i].exp_grant));
      wait_until(W_DONE, 400, $sformatf("v%0d_done_wait", i), w);
      check($sformatf("v%0d_done", i), 32'(done), 32'(vecs[i].exp_done));
      check($sformatf("v%0d_grant_drop", i), 32'(grant), 0);
      check($sformatf("v%0d_tx_avail", i), 32'(txif.tx_available), 1);
      wait_until(W_IDLE, 200, $sformatf("v%0d_idle_wait", i), w);
      check($sformatf("v%0d_gap_len", i), 32'(w), 48);
      tick();
    end

    // Both requesters held: strict alternation 0,1,0,1 and IFG respected.
    tx_busy_len = 30;
    maxaddr0    = 11'd59;
    maxaddr1    = 11'd99;
    req         = 2'b11;
    t_done      = -1000;
    for (int k = 0; k < 4; k++) begin
      wait_until(W_DOORBELL, 200, $sformatf("alt%0d_db_wait", k), w);
      t_db = cyc;
      check($sformatf("alt%0d_sel", k),     32'(sel), 32'(k % 2));
      check($sformatf("alt%0d_grant", k),   32'(grant), (k % 2) ? 32'd2 : 32'd1);
      check($sformatf("alt%0d_maxaddr", k), 32'(txif.tx_maxaddr), (k % 2) ? 32'd99 : 32'd59);
      if (k > 0) check($sformatf("alt%0d_ifg", k), 32'((t_db - t_done) >= 48), 1);
      tick();
      wait_until(W_DONE, 200, $sformatf("alt%0d_done_wait", k), w);
      t_done = cyc;
      check($sformatf("alt%0d_done", k), 32'(done), (k % 2) ? 32'd2 : 32'd1);
      if (k == 3) req = 2'b00;                  // last requester drops on done
      tick();
    end
    wait_until(W_IDLE, 200, "alt_idle_wait", w);
    tick();

    // Requester 1 arrives mid-frame; maxaddr0 change must not leak through.
    maxaddr0 = 11'd100;
    maxaddr1 = 11'd33;
    req      = 2'b01;
    wait_until(W_DOORBELL, 50, "mid_db_wait", w);
    check("mid_maxaddr0", 32'(txif.tx_maxaddr), 100);
    wait_until(W_TX_LOW, 50, "mid_txlow_wait", w);
    tick();
    req      = 2'b10;
    maxaddr0 = 11'd500;
    repeat (5) tick();
    check("mid_maxaddr_held", 32'(txif.tx_maxaddr), 100);
    check("mid_sel_held",     32'(sel), 0);
    check("mid_grant_held",   32'(grant), 1);
    wait_until(W_DONE, 100, "mid_done_wait", w);
    t_done = cyc;
    check("mid_done0", 32'(done), 1);
    tick();
    wait_until(W_GRANT, 100, "mid_regrant_wait", w);
    check("mid_grant1_delay", 32'(cyc - t_done), 49);
    check("mid_grant1",       32'(grant), 2);
    check("mid_maxaddr1",     32'(txif.tx_maxaddr), 33);
    req = 2'b00;
    wait_until(W_DONE, 100, "mid_done1_wait", w);
    check("mid_done1", 32'(done), 2);
    wait_until(W_IDLE, 100, "mid_idle_wait", w);
    tick();

    // Transmitter never starts: abort 16 cycles after doorbell, then re-grant.
    tx_stuck = 1'b1;
    maxaddr0 = 11'd12;
    req      = 2'b01;
    wait_until(W_DOORBELL, 50, "abt_db_wait", w);
    t_db      = cyc;
    done_seen = 1'b0;
    while (!abort && (cyc - t_db) < 40) begin
      tick();
      if (done != 2'b00) done_seen = 1'b1;
    end
    t_abort = cyc;
    check("abt_pulse",     32'(abort), 1);
    check("abt_delay",     32'(t_abort - t_db), 16);
    check("abt_no_done",   32'(done_seen), 0);
    check("abt_grant_drop", 32'(grant), 0);
    tx_stuck = 1'b0;
    tick();
    check("abt_single", 32'(abort), 0);
    wait_until(W_IDLE, 100, "abt_idle_wait", w);
    check("abt_gap", 32'(cyc - t_abort), 48);
    tick();
    check("abt_regrant_delay", 32'(cyc - t_abort), 49);
    check("abt_regrant", 32'(grant), 1);
    req = 2'b00;
    wait_until(W_DONE, 100, "abt_done_wait", w);
    check("abt_done_after", 32'(done), 1);
    wait_until(W_IDLE, 100, "abt_idle2_wait", w);
    tick();

    // Reset in the middle of WAIT_END; afterwards requester 0 wins the tie.
    maxaddr1 = 11'd77;
    req      = 2'b10;
    wait_until(W_DOORBELL, 50, "rst_db_wait", w);
    check("rst_pre_sel", 32'(sel), 1);
    wait_until(W_TX_LOW, 50, "rst_txlow_wait", w);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    check("mid_rst_grant",    32'(grant), 0);
    check("mid_rst_done",     32'(done), 0);
    check("mid_rst_abort",    32'(abort), 0);
    check("mid_rst_sel",      32'(sel), 0);
    check("mid_rst_doorbell", 32'(txif.tx_doorbell), 0);
    check("mid_rst_maxaddr",  32'(txif.tx_maxaddr), 0);
    check("mid_rst_busy",     32'(busy), 0);
    rst      = 1'b0;
    maxaddr0 = 11'd3;
    maxaddr1 = 11'd4;
    req      = 2'b11;
    tick();
    exp_g = 2'b01;
    check("post_rst_grant",   32'(grant), 32'(exp_g));
    check("post_rst_maxaddr", 32'(txif.tx_maxaddr), 3);
    req = 2'b00;
    wait_until(W_DONE, 100, "post_rst_done_wait", w);
    check("post_rst_done", 32'(done), 1);
    wait_until(W_IDLE, 100, "post_rst_idle_wait", w);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mac_tx_sched.md
Name: mac_tx_sched

Overview:
- Scheduler that shares the single RMII MAC transmit interface between two frame requesters, e.g. the data-frame builder and the control/ACK builder.
- Arbitrates round-robin between them and rings the transmitter's doorbell.
- Tracks transmitter availability to detect start and end of frame.
- Enforces the Ethernet inter-frame gap before the next grant.
- Drives the buffer select used by the top-level packet-buffer mux feeding the transmitter.

Parameters:
- IFG_CYCLES, 48, inter-frame gap in clk cycles (96 bit times at 2 bits/cycle).
- START_TIMEOUT, 16, max cycles from doorbell to transmitter going busy before abort.
- ADDR_W, 11, width of the packet-buffer max address.

Ports:
- clk  in  1  system clock (50 MHz RMII reference).
- rst  in  1  synchronous active-high reset.
- req  in  2  level request per requester; bit i set means buffer i holds a complete frame.
- maxaddr0  in  ADDR_W  last byte index of requester 0 frame.
- maxaddr1  in  ADDR_W  last byte index of requester 1 frame.
- grant  out  2  one-hot; requester may not modify its buffer while its bit is set.
- done  out  2  one-cycle pulse per requester when its frame has fully left the transmitter.
- abort  out  1  one-cycle pulse when START_TIMEOUT expires.
- sel  out  1  buffer select for the top-level pktbuf mux (0 = requester 0).
- tx_doorbell  out  1  to transmitter doorbell.
- tx_maxaddr  out  ADDR_W  to transmitter pktbuf_maxaddr.
- tx_available  in  1  from transmitter available.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- One clock domain (clk). Reset is synchronous, active-high.
- Reset values: state = IDLE, grant = 0, done = 0, abort = 0, sel = 0, tx_doorbell = 0, tx_maxaddr = 0, busy = 0, rr_last = 1 (requester 0 wins the first tie).
- Reset asserted mid-frame: all outputs return to reset values next cycle; the transmitter is reset by the same rst.
- All outputs are registered.
- States: IDLE, RING, WAIT_START, WAIT_END, GAP.
- IDLE:
  - If req != 0, pick the winner. A single requester wins outright. On a tie, the winner is the requester other than rr_last.
  - Register sel = winner, tx_maxaddr = maxaddr[winner], grant = onehot(winner), rr_last = winner.
  - Go to RING. Decision to doorbell latency is 1 cycle.
- RING: tx_doorbell = 1 for exactly one cycle; load the timeout counter; go to WAIT_START.
- WAIT_START:
  - tx_available == 0: go to WAIT_END.
  - Otherwise decrement the timeout counter. At 0: pulse abort, drop grant, no done pulse, go to GAP.
- WAIT_END: on tx_available == 1, pulse done[sel], drop grant, load the gap counter with IFG_CYCLES-1, go to GAP.
- GAP: count down to 0, then go to IDLE. A new doorbell is never issued less than IFG_CYCLES cycles after frame end.
- sel and tx_maxaddr hold their values from grant until the next IDLE decision. They never change while the transmitter is busy.
- Requester rules:
  - req deasserting while granted is ignored; the frame completes normally.
  - A requester must drop req in the cycle it sees done, or it will be re-served after the gap.
  - req held continuously by both requesters produces strict alternation 0,1,0,1...
- maxaddr inputs are sampled only in IDLE. Changes at other times have no effect.
- tx_available already low in IDLE (transmitter not yet idle after reset): grant anyway. WAIT_START sees 0 immediately; the later WAIT_END rising edge closes the frame. Documented corner case, covered by reset ordering.

Decomposition:
- mac_pkg holds: state enum, IFG_CYCLES default, ADDR_W, MAX_FRAME_BYTES = 1518.
- Arbiter is small enough to stay inline. Optional sub-module rr_arb2 for the round-robin pick; it is combinational and holds no state of its own.
- The pktbuf mux lives in the top-level wrapper, driven by sel.

Test Plan:
- req=01, maxaddr0=63, transmitter model drops available 2 cycles after doorbell and holds busy 256 cycles -> grant=01, single-cycle doorbell, tx_maxaddr=63, done[0] pulse on available rise, busy low exactly 48 cycles later.
- req=11 held, maxaddr0=59, maxaddr1=99 -> frames served 0,1,0,1 with sel toggling. Each doorbell is at least 48 cycles after the previous done. Every tx_maxaddr matches the granted requester.
- req=10 arrives during requester 0's WAIT_END, and maxaddr0 is changed mid-frame -> tx_maxaddr unchanged. Requester 1 is granted only after done[0] plus the 48-cycle gap.
- Transmitter model never drops available -> abort pulses 16 cycles after doorbell, done stays 0, grant drops, then the gap, then re-grant if req is still set.
- rst asserted in the middle of WAIT_END -> next cycle all outputs are at reset values, no done pulse. With req=11 afterwards, requester 0 wins the first grant.
